// File: rtl/imem_loader.sv
// imem_loader
//   Write side of the instruction-memory port. Receives a byte stream over a
//   valid/ready handshake, packs bytes big-endian into 32-bit words and writes
//   them to consecutive word addresses starting at 0. The CPU is held in reset
//   from an accepted start until the load completes.
//
// Ports
//   CLK, RST              clock; synchronous active-low reset
//   start, len            load request and word count (sampled in IDLE only)
//   byte_valid, byte_data input byte stream (first byte = bits [31:24])
//   byte_ready            loader takes a byte this cycle
//   mem_addr, mem_data    write address (byte, word-aligned) and data
//   InsMemRW              1 = read mode, 0 = write this edge
//   cpu_hold              CPU reset; 1 = held
//   busy, done, err       status: load active, completion pulse, rejected start
//   checksum              mod-2^32 sum of words written by the last load
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        InsMemRW,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (32'(len) > 32'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            sum_d   = '0;
            hold_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            len_d   = len;
            state_d = (len == 8'd0) ? S_DONE : S_RECV;
          end
        end
      end
      S_RECV: begin
        // ready_q is 1 throughout RECV, so byte_valid alone marks a handshake
        if (byte_valid && ready_q) begin
          word_d = {word_q[23:0], byte_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Address/data are registered on the edge entering WRITE so they
            // are stable for the whole write cycle.
            addr_d  = {22'd0, idx_q, 2'b00};
            data_d  = {word_q[23:0], byte_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        sum_d = sum_q + word_q;
        idx_d = idx_q + 8'd1;
        if (idx_d == len_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state, so they line up with the state
    ready_d = (state_d == S_RECV);
    rw_d    = (state_d != S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rw_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign byte_ready = ready_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign InsMemRW   = rw_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte streams checked against a word-list
// reference (expected writes, checksum and latency derived from the words).
module tb_imem_loader;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        InsMemRW;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  always #5 CLK = ~CLK;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .InsMemRW(InsMemRW),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [0:255];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int done_cnt = 0;
  int ready_in_write = 0;

  // Passive recorder of write cycles and done pulses
  always @(negedge CLK) begin
    if (RST) begin
      if (InsMemRW === 1'b0) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_data);
        if (byte_ready !== 1'b0) ready_in_write++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input int bi);
    logic [31:0] w;
    w = wbuf[bi / 4];
    return w[8 * (3 - (bi % 4)) +: 8];
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    ready_in_write = 0;
  endtask

  // mode 0: stream never stalls, 1: valid every other cycle, 2: random valid
  task automatic run_load(input int n, input int mode, input bit b2b, input string tag);
    int bi, cyc, total, budget;
    bit got;
    logic [31:0] exp_sum;
    clear_mon();
    exp_sum = '0;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + wbuf[i];
    @(posedge CLK); #1;
    start = 1'b1; len = 8'(n); byte_valid = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    bi = 0; total = 4 * n; cyc = 0; got = 1'b0; budget = 40 * n + 20;
    while (cyc < budget) begin
      case (mode)
        0: byte_valid = (bi < total);
        1: byte_valid = (bi < total) && (cyc % 2 == 0);
        default: byte_valid = (bi < total) && ($urandom_range(0, 1) == 1);
      endcase
      byte_data = byte_valid ? byte_of(bi) : 8'($urandom);
      @(negedge CLK);
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || byte_ready !== (n > 0)) begin
          errors++;
          $display("FAIL %s accept: busy=%b err=%b ready=%b required busy=1 err=0 ready=%0d",
                   tag, busy, err, byte_ready, n > 0);
        end
      end
      if (byte_valid && byte_ready) bi++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      cyc++;
      @(posedge CLK); #1;
    end
    byte_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, budget);
    end else begin
      if (mode == 0) begin
        checks++;
        if (cyc != 5 * n) begin
          errors++;
          $display("FAIL %s latency: %0d cycles, required %0d", tag, cyc, 5 * n);
        end
      end
      checks++;
      if (checksum !== exp_sum) begin
        errors++;
        $display("FAIL %s checksum: got %h required %h", tag, checksum, exp_sum);
      end
      checks++;
      if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s done_cycle: cpu_hold=%b busy=%b required 1 1", tag, cpu_hold, busy);
      end
      if (b2b) begin
        start = 1'b1; len = 8'd1;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      checks++;
      if ({cpu_hold, busy, done, InsMemRW, byte_ready} !== 5'b00010) begin
        errors++;
        $display("FAIL %s after_done: hold/busy/done/rw/ready=%b required 00010", tag,
                 {cpu_hold, busy, done, InsMemRW, byte_ready});
      end
      checks++;
      if (checksum !== exp_sum) begin
        errors++;
        $display("FAIL %s checksum_stable: got %h required %h", tag, checksum, exp_sum);
      end
    end
    checks++;
    if (wr_addr_q.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wr_addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== wbuf[i]) begin
          errors++;
          $display("FAIL %s write%0d: addr %h data %h required addr %h data %h", tag, i,
                   wr_addr_q[i], wr_data_q[i], 32'(4 * i), wbuf[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt);
    end
    checks++;
    if (ready_in_write != 0 || bi != total) begin
      errors++;
      $display("FAIL %s stream: ready_in_write=%0d bytes_taken=%0d required 0 and %0d",
               tag, ready_in_write, bi, total);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({cpu_hold, byte_ready, InsMemRW, busy, done, err} !== 6'b101000) begin
      errors++;
      $display("FAIL reset_ctrl: hold/ready/rw/busy/done/err=%b required 101000",
               {cpu_hold, byte_ready, InsMemRW, busy, done, err});
    end
    checks++;
    if ({checksum, mem_addr, mem_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: checksum=%h addr=%h data=%h required all 0",
               checksum, mem_addr, mem_data);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_err(input logic exp_hold);
    clear_mon();
    @(posedge CLK); #1;
    start = 1'b1; len = 8'(DEPTH + 1);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if ({err, busy, byte_ready, cpu_hold} !== {3'b100, exp_hold}) begin
      errors++;
      $display("FAIL err_set: err/busy/ready/hold=%b required %b",
               {err, busy, byte_ready, cpu_hold}, {3'b100, exp_hold});
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (wr_addr_q.size() != 0 || done_cnt != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_idle: writes=%0d dones=%0d err=%b required 0 0 1",
               wr_addr_q.size(), done_cnt, err);
    end
    wbuf[0] = $urandom;
    run_load(1, 0, 1'b0, "err_clear");
  endtask

  task automatic test_basic();
    wbuf[0] = 32'h20080005; wbuf[1] = 32'h00000008;
    run_load(2, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    wbuf[0] = 32'h20080005; wbuf[1] = 32'h00000008;
    run_load(2, 1, 1'b0, "stall");
  endtask

  task automatic test_len0();
    run_load(0, 0, 1'b0, "len0");
  endtask

  task automatic test_wrap();
    wbuf[0] = 32'hFFFFFFFF; wbuf[1] = 32'h00000002;
    run_load(2, 0, 1'b0, "wrap");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    run_load(3, 0, 1'b1, "b2b_first");
    wbuf[0] = $urandom;
    run_load(1, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    run_load(DEPTH, 0, 1'b0, "full");
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      run_load(n, 2, 1'b0, "random");
    end
  endtask

  task automatic test_reset_midload();
    int bi, cyc;
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    clear_mon();
    @(posedge CLK); #1;
    start = 1'b1; len = 8'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    bi = 0; cyc = 0;
    while (bi < 6 && cyc < 50) begin
      // an oversized start mid-load must be ignored and leave err clear
      start = (cyc == 2);
      len = (cyc == 2) ? 8'(DEPTH + 1) : 8'd3;
      byte_valid = 1'b1;
      byte_data = byte_of(bi);
      @(negedge CLK);
      if (byte_valid && byte_ready) bi++;
      cyc++;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    RST = 1'b0;
    checks++;
    if (bi != 6 || err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midload_progress: bytes=%0d err=%b busy=%b required 6 0 1", bi, err, busy);
    end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({cpu_hold, byte_ready, InsMemRW, busy, done, err} !== 6'b101000) begin
      errors++;
      $display("FAIL midload_reset_ctrl: hold/ready/rw/busy/done/err=%b required 101000",
               {cpu_hold, byte_ready, InsMemRW, busy, done, err});
    end
    checks++;
    if ({checksum, mem_addr, mem_data} !== 96'd0) begin
      errors++;
      $display("FAIL midload_reset_data: checksum=%h addr=%h data=%h required all 0",
               checksum, mem_addr, mem_data);
    end
    checks++;
    if (wr_addr_q.size() != 1 || done_cnt != 0) begin
      errors++;
      $display("FAIL midload_writes: writes=%0d dones=%0d required 1 0",
               wr_addr_q.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== wbuf[0]) begin
        errors++;
        $display("FAIL midload_write0: addr %h data %h required 00000000 %h",
                 wr_addr_q[0], wr_data_q[0], wbuf[0]);
      end
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    run_load(2, 0, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_err(1'b1);
    test_basic();
    test_stall();
    test_err(1'b0);
    test_len0();
    test_wrap();
    test_back_to_back();
    test_full();
    test_random();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
